collatz_scan: RTL and testbench

- Sequencer that sits in front of the range block (the 16-entry Collatz count RAM) and drives its go/start/done/count interface.
- On a host request it launches range with a base number and waits for range done.
- It then sweeps the count RAM through range's read port and reduces the RAM_WORDS counts to a maximum, its index, the corresponding starting number, and a total.
- It gives the host a single-request, single-result view of a whole Collatz sweep.

---
 rtl/collatz_scan.sv | 173 +++++++++++++++++
 tb/tb_collatz_scan.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_scan.sv
// collatz_scan: sequencer in front of the 16-entry Collatz count RAM block.
// A host request launches the range block with a base number, waits for its
// done pulse, then sweeps the count RAM through the read port. The counts are
// reduced to a maximum, the lowest index holding it, the matching start number
// and a total.
//
// Ports:
//   clk, reset_n          clock (posedge) and asynchronous active-low reset
//   req, base             host request and first start number
//   busy                  run in progress (accepted req until back in IDLE)
//   result_valid, error   results valid / last run timed out on range_done
//   max_count, max_index  largest count and lowest index holding it
//   max_n                 base + max_index, 32-bit wrap
//   sum_count             sum of all counts
//   range_go, range_start start pulse and start number / read address to range
//   range_done, range_count  finished pulse and registered read data from range
//
// state  | meaning
// IDLE   | waiting for req; results and error held
// LAUNCH | one-cycle range_go with range_start = base_q
// WAIT   | waiting for range_done, timeout down-counter running
// READ   | presenting addresses 0..RAM_WORDS-1, accumulating returned counts
// FINAL  | folding in the last count and publishing results

module collatz_scan #(
  parameter int          RAM_WORDS      = 16,
  parameter int          RAM_ADDR_BITS  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req,
  input  logic [31:0]                 base,
  output logic                        busy,
  output logic                        result_valid,
  output logic                        error,
  output logic [15:0]                 max_count,
  output logic [RAM_ADDR_BITS-1:0]    max_index,
  output logic [31:0]                 max_n,
  output logic [16+RAM_ADDR_BITS-1:0] sum_count,
  output logic                        range_go,
  output logic [31:0]                 range_start,
  input  logic                        range_done,
  input  logic [15:0]                 range_count
);

  localparam int SUM_W = 16 + RAM_ADDR_BITS;
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);
  // Terminal count of the wait timer: zero is reached on the last allowed WAIT cycle.
  localparam logic [31:0] TMO_LOAD = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;

  logic [2:0]               state;
  logic [31:0]              base_q;
  logic [31:0]              tmo_cnt;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic                     pend_valid;
  logic [RAM_ADDR_BITS-1:0] pend_idx;
  logic [15:0]              acc_max;
  logic [RAM_ADDR_BITS-1:0] acc_idx;
  logic [SUM_W-1:0]         acc_sum;

  logic                     cnt_gt;
  logic [15:0]              nxt_max;
  logic [RAM_ADDR_BITS-1:0] nxt_idx;
  logic [SUM_W-1:0]         nxt_sum;

  // Strict compare so ties keep the earliest (lowest) index.
  always_comb begin
    cnt_gt  = range_count > acc_max;
    nxt_max = cnt_gt ? range_count : acc_max;
    nxt_idx = cnt_gt ? pend_idx : acc_idx;
    nxt_sum = acc_sum + SUM_W'(range_count);
  end

  always_comb begin
    busy        = (state != S_IDLE);
    range_go    = (state == S_LAUNCH);
    range_start = 32'd0;
    case (state)
      S_LAUNCH, S_WAIT: range_start = base_q;
      S_READ:           range_start = {{(32-RAM_ADDR_BITS){1'b0}}, rd_addr};
      default:          range_start = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      base_q       <= '0;
      tmo_cnt      <= '0;
      rd_addr      <= '0;
      pend_valid   <= 1'b0;
      pend_idx     <= '0;
      acc_max      <= '0;
      acc_idx      <= '0;
      acc_sum      <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      max_count    <= '0;
      max_index    <= '0;
      max_n        <= '0;
      sum_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            base_q       <= base;
            result_valid <= 1'b0;
            error        <= 1'b0;
            acc_max      <= '0;
            acc_idx      <= '0;
            acc_sum      <= '0;
            max_count    <= '0;
            max_index    <= '0;
            max_n        <= '0;
            sum_count    <= '0;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_cnt <= TMO_LOAD;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // done has priority over a coincident timeout
          if (range_done) begin
            rd_addr    <= '0;
            pend_valid <= 1'b0;
            state      <= S_READ;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'd0)) begin
            error        <= 1'b1;
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
          end
        end
        S_READ: begin
          // RAM data lags the address by one cycle; pend_* names the read in flight.
          pend_valid <= 1'b1;
          pend_idx   <= rd_addr;
          if (pend_valid) begin
            acc_max <= nxt_max;
            acc_idx <= nxt_idx;
            acc_sum <= nxt_sum;
          end
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == LAST_ADDR) state <= S_FINAL;
        end
        S_FINAL: begin
          max_count    <= nxt_max;
          max_index    <= nxt_idx;
          max_n        <= base_q + 32'(nxt_idx);
          sum_count    <= nxt_sum;
          acc_max      <= nxt_max;
          acc_idx      <= nxt_idx;
          acc_sum      <= nxt_sum;
          pend_valid   <= 1'b0;
          result_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_scan.sv
module tb_collatz_scan;

  typedef struct {
    logic [15:0] mc;
    logic [3:0]  mi;
    logic [31:0] mn;
    logic [19:0] sc;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [31:0] base;
  logic        busy, result_valid, error;
  logic [15:0] max_count;
  logic [3:0]  max_index;
  logic [31:0] max_n;
  logic [19:0] sum_count;
  logic        range_go;
  logic [31:0] range_start;
  logic        range_done;
  logic [15:0] range_count;

  logic        stub_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        done_en   = 1'b1;
  logic [15:0] counts [16];
  logic [15:0] rd_q = 16'd0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   go_cyc = 0;
  int   gos = 0;
  logic addr_chk = 1'b0;
  logic [31:0] exp_start = 32'd0;
  logic prev_rv = 1'b0;
  logic prev_er = 1'b0;
  exp_t sb[$];

  assign range_done  = stub_done | spur_done;
  assign range_count = rd_q;

  collatz_scan #(.RAM_WORDS(16), .RAM_ADDR_BITS(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .base(base), .busy(busy),
    .result_valid(result_valid), .error(error), .max_count(max_count),
    .max_index(max_index), .max_n(max_n), .sum_count(sum_count),
    .range_go(range_go), .range_start(range_start), .range_done(range_done),
    .range_count(range_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // range stub: registered read port
  always @(posedge clk) rd_q <= counts[range_start[3:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // range stub: done pulse three cycles after go
  initial begin
    forever begin
      @(negedge clk);
      if (range_go && done_en) begin
        repeat (3) @(posedge clk);
        #1 stub_done = 1'b1;
        @(posedge clk);
        #1 stub_done = 1'b0;
      end
    end
  end

  // go / address monitor
  always @(negedge clk) begin
    if (!reset_n) addr_chk = 1'b0;
    if (range_go) begin
      gos++;
      go_cyc = cyc;
      chk("go_start", range_start, exp_start);
    end
    if (stub_done) begin
      done_cyc = cyc;
      addr_chk = 1'b1;
    end else if (addr_chk && cyc > done_cyc && cyc <= done_cyc + 16) begin
      chk("rd_addr", range_start, 32'(cyc - done_cyc - 1));
      if (cyc == done_cyc + 16) addr_chk = 1'b0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if ((result_valid && !prev_rv) || (error && !prev_er)) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_result: rv=%0b err=%0b with no expectation", result_valid, error);
      end else begin
        e = sb.pop_front();
        chk("error", error, e.er);
        chk("busy", busy, 0);
        if (e.er) begin
          chk("rv_on_timeout", result_valid, 0);
          chk("timeout_cycle", cyc, go_cyc + 101);
        end else begin
          chk("max_count", max_count, e.mc);
          chk("max_index", max_index, e.mi);
          chk("max_n", max_n, e.mn);
          chk("sum_count", sum_count, e.sc);
          chk("rv_cycle", cyc, done_cyc + 18);
        end
      end
    end
    prev_rv = result_valid;
    prev_er = error;
  end

  task automatic do_req(input logic [31:0] b);
    @(posedge clk);
    #1 req = 1'b1;
    base = b;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", lim);
    end
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!stub_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!stub_done) begin
      errors++;
      checks++;
      $display("FAIL wait_done: no range_done after %0d cycles", lim);
    end
  endtask

  task automatic run_scn(input logic [31:0] b, input exp_t e);
    gos = 0;
    exp_start = b;
    sb.push_back(e);
    do_req(b);
    wait_idle(400);
    repeat (2) @(negedge clk);
    chk("go_count", gos, 1);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 16; k++) counts[k] = 16'(k + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_max"}, max_count, 0);
    chk({tag, "_idx"}, max_index, 0);
    chk({tag, "_maxn"}, max_n, 0);
    chk({tag, "_sum"}, sum_count, 0);
    chk({tag, "_go"}, range_go, 0);
    chk({tag, "_start"}, range_start, 0);
  endtask

  initial begin
    exp_t e1, e;
    reset_n = 1'b0;
    req = 1'b0;
    base = 32'd0;
    for (int k = 0; k < 16; k++) counts[k] = 16'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // ramp 1..16, base 1
    fill_ramp();
    e1 = '{mc: 16'd16, mi: 4'd15, mn: 32'd16, sc: 20'd136, er: 1'b0};
    run_scn(32'd1, e1);

    // all counts tie at 5
    for (int k = 0; k < 16; k++) counts[k] = 16'd5;
    e = '{mc: 16'd5, mi: 4'd0, mn: 32'd100, sc: 20'd80, er: 1'b0};
    run_scn(32'd100, e);

    // max_n wraps past 2^32
    for (int k = 0; k < 16; k++) counts[k] = 16'd0;
    counts[12] = 16'h0200;
    e = '{mc: 16'h0200, mi: 4'd12, mn: 32'h0000_0004, sc: 20'h00200, er: 1'b0};
    run_scn(32'hFFFF_FFF8, e);

    // timeout: no done
    done_en = 1'b0;
    e = '{mc: 16'd0, mi: 4'd0, mn: 32'd0, sc: 20'd0, er: 1'b1};
    run_scn(32'd7, e);
    done_en = 1'b1;

    // ignored req pulses and spurious done; next req clears error
    fill_ramp();
    gos = 0;
    exp_start = 32'd1;
    sb.push_back(e1);
    do_req(32'd1);
    @(negedge clk);
    chk("err_clear", error, 0);
    @(posedge clk);
    #1 req = 1'b1;
    base = 32'd55;
    @(posedge clk);
    #1 req = 1'b0;
    wait_done(50);
    repeat (3) @(posedge clk);
    #1 req = 1'b1;
    spur_done = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    spur_done = 1'b0;
    wait_idle(400);
    repeat (2) @(negedge clk);
    chk("go_count_busy_req", gos, 1);

    // reset mid-READ, then a clean rerun
    gos = 0;
    exp_start = 32'd1;
    do_req(32'd1);
    wait_done(50);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    run_scn(32'd1, e1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
